// File: rtl/uart_tx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_ctrl
//
// Transmit-side buffer and launch controller placed directly in front of the
// UART transmitter. The host pushes bytes at up to one per clock into a
// DEPTH-entry circular FIFO. The controller drains the FIFO one frame at a
// time: it presents the byte on tx_data_o, pulses tx_start_o for one cycle,
// then waits for a rising edge on tx_done_i before launching the next byte.
// This lets software burst a whole message without polling per byte.
//
// Parameters:
//   DATA_W  byte width, must match the transmitter data input
//   DEPTH   FIFO entries, power of two, >= 2
//   ADDR_W  pointer width, log2(DEPTH)
//
// Ports:
//   clk_i       in   system clock, rising edge
//   rst_ni      in   asynchronous active-low reset, synchronous release
//   wr_en_i     in   host write strobe, accepted only when not full
//   wr_data_i   in   host byte
//   full_o      out  FIFO holds DEPTH entries
//   empty_o     out  FIFO holds no entries
//   count_o     out  stored entries, 0..DEPTH
//   tx_start_o  out  one-cycle launch pulse to the transmitter
//   tx_data_o   out  byte being transmitted, stable until completion
//   tx_done_i   in   transmitter completion (pulse or level)
//   busy_o      out  a frame is in flight
//   ovf_o       out  sticky overflow flag (optional feature)
//   ovf_clr_i   in   clears ovf_o (optional feature)
//
// Optional feature macro: UART_TXF_OVF_FLAG_EN
//   Defined   : ovf_o sets on a write attempt while full, clears on ovf_clr_i;
//               a set and clear on the same edge leaves the flag set.
//   Undefined : ovf_o is tied low and ovf_clr_i is ignored.
// -----------------------------------------------------------------------------
module uart_tx_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              ovf_o,
  input  logic              ovf_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Storage array: written on its own clock-only process so it can map onto
  // RAM; the read is registered into tx_data_q at pop time.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              full_q;
  logic              empty_q;
  logic              done_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              busy_q;
  state_t            state_q;

  logic wr_accept;
  logic pop;
  logic done_rise;

  // A write while full is dropped even if a pop happens on the same edge,
  // because full_q reflects the count before that edge.
  assign wr_accept = wr_en_i & ~full_q;

  // Pops only ever happen leaving IDLE. empty_q is the pre-edge state, so a
  // byte being written on this edge is never the one popped.
  assign pop = (state_q == ST_IDLE) & ~empty_q;

  // Only a fresh rising edge of tx_done_i ends a frame, so a level-style
  // done left high from the previous frame cannot release the next one.
  assign done_rise = tx_done_i & ~done_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // FIFO bookkeeping, completion edge detector and launch FSM. Flags are
  // registered from the next-state count so the outputs come straight off
  // flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL_CNT);
      empty_q  <= (count_d == '0);
      done_q   <= tx_done_i;

      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // Completion is not looked at here: the transmitter has only just
          // seen the start strobe.
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_rise) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = busy_q;

`ifdef UART_TXF_OVF_FLAG_EN
  logic ovf_q;

  // Set has priority over clear so an overflow coinciding with a clear is
  // never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (wr_en_i & full_q) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr_i;
  assign ovf_o          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_ctrl
//
// Directed bench for uart_tx_fifo_ctrl with a small transmitter model that
// answers each tx_start with tx_done after tx_delay cycles, either as a
// one-cycle pulse or as a level that stays high into the next frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

`ifdef UART_TXF_OVF_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              wr_en_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   count_o;
  logic              tx_start_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_done_i = 1'b0;
  logic              busy_o;
  logic              ovf_o;
  logic              ovf_clr_i;

  uart_tx_fifo_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .tx_done_i  (tx_done_i),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] starts[$];
  int         start_cyc[$];

  bit level_mode = 1'b0;
  bit hang       = 1'b0;
  int tx_delay   = 5;
  int tx_cnt     = 0;
  int tx_hold    = 0;
  bit inflight   = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Transmitter model, evaluated on the falling edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      tx_done_i = 1'b0;
      inflight  = 1'b0;
      tx_cnt    = 0;
      tx_hold   = 0;
    end else begin
      if (!level_mode && tx_done_i) tx_done_i = 1'b0;
      if (tx_hold > 0) begin
        tx_hold = tx_hold - 1;
        if (tx_hold == 0) tx_done_i = 1'b0;
      end
      if (tx_start_o) begin
        starts.push_back(tx_data_o);
        start_cyc.push_back(cyc);
        if (level_mode && tx_done_i) tx_hold = 3;
        inflight = 1'b1;
        tx_cnt   = tx_delay;
      end else if (inflight && !hang) begin
        tx_cnt = tx_cnt - 1;
        if (tx_cnt <= 0) begin
          tx_done_i = 1'b1;
          inflight  = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] start_at(input int i);
    if (i < starts.size()) return starts[i];
    return 8'hxx;
  endfunction

  function automatic int gap_at(input int i);
    if (i + 1 < start_cyc.size()) return start_cyc[i+1] - start_cyc[i];
    return -1;
  endfunction

  task automatic clear_log();
    starts.delete();
    start_cyc.delete();
  endtask

  // Called just after a falling edge; drives for one rising edge.
  task automatic write_byte(input logic [7:0] b);
    wr_en_i   = 1'b1;
    wr_data_i = b;
    @(negedge clk_i);
    wr_en_i   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (!busy_o && empty_o) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_empty"}, 32'(empty_o), 32'd1);
    check({tag, "_full"}, 32'(full_o), 32'd0);
    check({tag, "_start"}, 32'(tx_start_o), 32'd0);
    check({tag, "_data"}, 32'(tx_data_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         sent;
    int         guard;
    int         max_cnt;

    wr_en_i   = 1'b0;
    wr_data_i = '0;
    ovf_clr_i = 1'b0;
    rst_ni    = 1'b1;

    // Reset: checked before any clock edge, so it must act asynchronously.
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (3) @(negedge clk_i);
    #3 rst_ni = 1'b1;
    @(negedge clk_i);

    // Single byte.
    tx_delay = 5;
    clear_log();
    write_byte(8'hAC);
    check("t1_count_wr", 32'(count_o), 32'd1);
    check("t1_empty_wr", 32'(empty_o), 32'd0);
    check("t1_start_early", 32'(tx_start_o), 32'd0);
    @(negedge clk_i);
    check("t1_start", 32'(tx_start_o), 32'd1);
    check("t1_data", 32'(tx_data_o), 32'hAC);
    check("t1_busy", 32'(busy_o), 32'd1);
    check("t1_count_pop", 32'(count_o), 32'd0);
    check("t1_empty_pop", 32'(empty_o), 32'd1);
    @(negedge clk_i);
    check("t1_start_width", 32'(tx_start_o), 32'd0);
    check("t1_busy_hold", 32'(busy_o), 32'd1);
    wait_idle(100, "t1");
    check("t1_nstarts", 32'(starts.size()), 32'd1);
    check("t1_logged", 32'(start_at(0)), 32'hAC);
    check("t1_data_held", 32'(tx_data_o), 32'hAC);
    $display("t1 single byte: starts=%0d", starts.size());

    // Burst and order, pulse done 20 cycles after each start.
    tx_delay = 20;
    clear_log();
    for (int i = 1; i <= 5; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(i);
      @(negedge clk_i);
    end
    wr_en_i = 1'b0;
    wait_idle(400, "t2");
    check("t2_nstarts", 32'(starts.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_data%0d", i), 32'(start_at(i)), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_gap%0d", i), 32'(gap_at(i)), 32'd22);
    end
    $display("t2 burst: starts=%0d", starts.size());

    // Full and drop, transmitter stalled.
    hang     = 1'b1;
    tx_delay = 3;
    clear_log();
    for (int i = 0; i < 17; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(8'h10 + i);
      @(negedge clk_i);
    end
    wr_en_i = 1'b0;
    check("t3_count_full", 32'(count_o), 32'd16);
    check("t3_full", 32'(full_o), 32'd1);
    check("t3_empty", 32'(empty_o), 32'd0);
    check("t3_ovf_none", 32'(ovf_o), 32'd0);
    write_byte(8'h55);
    check("t3_drop_count", 32'(count_o), 32'd16);
    check("t3_ovf_set", 32'(ovf_o), 32'(OVF_EN));
    ovf_clr_i = 1'b1;
    @(negedge clk_i);
    ovf_clr_i = 1'b0;
    check("t3_ovf_clr", 32'(ovf_o), 32'd0);
    wr_en_i   = 1'b1;
    wr_data_i = 8'h66;
    ovf_clr_i = 1'b1;
    @(negedge clk_i);
    wr_en_i   = 1'b0;
    ovf_clr_i = 1'b0;
    check("t3_ovf_setwins", 32'(ovf_o), 32'(OVF_EN));
    check("t3_drop_count2", 32'(count_o), 32'd16);
    ovf_clr_i = 1'b1;
    @(negedge clk_i);
    ovf_clr_i = 1'b0;
    check("t3_ovf_clr2", 32'(ovf_o), 32'd0);
    check("t3_nstarts_stall", 32'(starts.size()), 32'd1);
    check("t3_first", 32'(start_at(0)), 32'h10);
    check("t3_data_stable", 32'(tx_data_o), 32'h10);
    check("t3_busy_stall", 32'(busy_o), 32'd1);
    hang = 1'b0;
    wait_idle(600, "t3");
    check("t3_nstarts", 32'(starts.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("t3_data%0d", i), 32'(start_at(i)), 32'(8'h10 + i));
    end
    $display("t3 full/drop: starts=%0d", starts.size());

    // Level-style done held high between frames.
    level_mode = 1'b1;
    tx_delay   = 10;
    clear_log();
    for (int i = 0; i < 3; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(8'h31 + i);
      @(negedge clk_i);
    end
    wr_en_i = 1'b0;
    wait_idle(300, "t4");
    check("t4_nstarts", 32'(starts.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_data%0d", i), 32'(start_at(i)), 32'(8'h31 + i));
    end
    check("t4_gap0", 32'(gap_at(0)), 32'd12);
    check("t4_gap1", 32'(gap_at(1)), 32'd12);
    check("t4_done_level", 32'(tx_done_i), 32'd1);
    write_byte(8'h34);
    @(negedge clk_i);
    check("t4_start_lvl", 32'(tx_start_o), 32'd1);
    repeat (8) @(negedge clk_i);
    check("t4_busy_lvl", 32'(busy_o), 32'd1);
    wait_idle(100, "t4b");
    check("t4_nstarts2", 32'(starts.size()), 32'd4);
    level_mode = 1'b0;
    repeat (2) @(negedge clk_i);
    $display("t4 level done: starts=%0d", starts.size());

    // Wrap-around with a random writer.
    tx_delay = 2;
    clear_log();
    sent    = 0;
    guard   = 0;
    max_cnt = 0;
    while (sent < 40 && guard < 2000) begin
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      if (!full_o && $urandom_range(0, 3) != 0) begin
        b = 8'($urandom_range(0, 255));
        wr_en_i   = 1'b1;
        wr_data_i = b;
        exp_q.push_back(b);
        sent++;
      end else begin
        wr_en_i = 1'b0;
      end
      @(negedge clk_i);
      guard++;
    end
    wr_en_i = 1'b0;
    if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    check("t5_sent", 32'(sent), 32'd40);
    wait_idle(1000, "t5");
    check("t5_nstarts", 32'(starts.size()), 32'd40);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("t5_data%0d", i), 32'(start_at(i)), 32'(exp_q[i]));
    end
    check("t5_max_le_depth", 32'(max_cnt <= DEPTH), 32'd1);
    $display("t5 wrap: starts=%0d max_count=%0d", starts.size(), max_cnt);

    // Reset mid-frame.
    hang = 1'b1;
    clear_log();
    for (int i = 0; i < 3; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'(8'h41 + i);
      @(negedge clk_i);
    end
    wr_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("t6_busy_wait", 32'(busy_o), 32'd1);
    check("t6_count_q", 32'(count_o), 32'd2);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("t6_rst");
    @(negedge clk_i);
    #3 rst_ni = 1'b1;
    @(negedge clk_i);
    hang = 1'b0;
    clear_log();
    repeat (30) @(negedge clk_i);
    check("t6_no_start", 32'(starts.size()), 32'd0);
    check("t6_idle", 32'(busy_o), 32'd0);
    write_byte(8'h77);
    wait_idle(100, "t6");
    check("t6_nstarts", 32'(starts.size()), 32'd1);
    check("t6_data", 32'(start_at(0)), 32'h77);
    $display("t6 reset mid-frame: starts=%0d", starts.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
